// File: rtl/packet_handler_arbiter_if.sv
// Bus bundle between packet_handler_arbiter, the rx/tx packet buffers and the protocol handlers.
// The master modport is the arbiter's view; slave is the buffers/handlers side.
interface packet_handler_arbiter_if #(
    parameter int N_HANDLERS = 3
);
    logic                       rx_packet_ready;
    logic                       rx_done;
    logic [9:0]                 rx_read_addr;
    logic [N_HANDLERS-1:0]      hnd_ready;
    logic [N_HANDLERS-1:0]      hnd_done;
    logic [N_HANDLERS-1:0]      hnd_xmit;
    logic [10*N_HANDLERS-1:0]   hnd_read_addr;
    logic [8*N_HANDLERS-1:0]    hnd_out;
    logic [10*N_HANDLERS-1:0]   hnd_out_addr;
    logic [N_HANDLERS-1:0]      hnd_out_we;
    logic [10*N_HANDLERS-1:0]   hnd_out_len;
    logic [7:0]                 tx_data;
    logic [9:0]                 tx_addr;
    logic                       tx_we;
    logic [9:0]                 tx_len;
    logic                       tx_start;
    logic                       tx_done;

    modport master (
        input  rx_packet_ready, hnd_done, hnd_xmit, hnd_read_addr, hnd_out,
               hnd_out_addr, hnd_out_we, hnd_out_len, tx_done,
        output rx_done, rx_read_addr, hnd_ready, tx_data, tx_addr, tx_we,
               tx_len, tx_start
    );

    modport slave (
        output rx_packet_ready, hnd_done, hnd_xmit, hnd_read_addr, hnd_out,
               hnd_out_addr, hnd_out_we, hnd_out_len, tx_done,
        input  rx_done, rx_read_addr, hnd_ready, tx_data, tx_addr, tx_we,
               tx_len, tx_start
    );
endinterface

// File: rtl/packet_handler_arbiter.sv
// Offers one received frame to N handlers in priority order; the first claimer's reply is sent.
// Optional per-handler watchdog enabled by defining ARB_TIMEOUT_EN.
module packet_handler_arbiter #(
    parameter int N_HANDLERS     = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                      mac_clk,
    input logic                      reset,
    packet_handler_arbiter_if.master bus
);
    localparam int SEL_W = (N_HANDLERS > 1) ? $clog2(N_HANDLERS) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_HANDLERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OFFER,
        S_DRAIN,
        S_TX,
        S_TXWAIT,
        S_RELEASE,
        S_RXCLR
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_next_sel;
    logic             r_xmit_l;
    logic             w_next_xmit_l;
    logic [9:0]       r_tx_len;
    logic [9:0]       w_next_tx_len;
    logic             w_offer;
    logic             w_grant;
    logic             w_sel_done;
    logic             w_timeout;

    assign w_offer    = (r_state == S_OFFER);
    assign w_grant    = w_offer || (r_state == S_DRAIN);
    assign w_sel_done = bus.hnd_done[r_sel];

`ifdef ARB_TIMEOUT_EN
    localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT_CYCLES - 1);
    logic [11:0] r_timer;

    // OFFER is always entered from a non-OFFER state, so the count starts at zero on entry.
    always_ff @(posedge mac_clk) begin
        if (reset || !w_offer) r_timer <= '0;
        else                   r_timer <= r_timer + 12'd1;
    end

    assign w_timeout = w_offer && (r_timer == TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        bus.hnd_ready = '0;
        if (w_offer) bus.hnd_ready[r_sel] = 1'b1;
    end

    assign bus.rx_read_addr = w_grant ? bus.hnd_read_addr[10*r_sel +: 10] : '0;
    assign bus.tx_we        = w_offer && bus.hnd_out_we[r_sel];
    assign bus.tx_addr      = w_offer ? bus.hnd_out_addr[10*r_sel +: 10] : '0;
    assign bus.tx_data      = w_offer ? bus.hnd_out[8*r_sel +: 8] : '0;
    assign bus.tx_len       = r_tx_len;
    assign bus.tx_start     = (r_state == S_TX);
    assign bus.rx_done      = (r_state == S_RELEASE);

    always_ff @(posedge mac_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
        // NOTE: synchronous reset clears every register; there is no memory array to leave unreset.
        if (reset) begin
            r_state  <= S_IDLE;
            r_sel    <= '0;
            r_xmit_l <= 1'b0;
            r_tx_len <= '0;
        end else begin
            r_state  <= w_next_state;
            r_sel    <= w_next_sel;
            r_xmit_l <= w_next_xmit_l;
            r_tx_len <= w_next_tx_len;
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first so no path through the case infers a latch.
        w_next_state  = r_state;
        w_next_sel    = r_sel;
        w_next_xmit_l = r_xmit_l;
        w_next_tx_len = r_tx_len;

        unique case (r_state)
            S_IDLE: begin
                if (bus.rx_packet_ready) begin
                    w_next_sel   = '0;
                    w_next_state = S_OFFER;
                end
            end
            S_OFFER: begin
                // A done arriving in the expiry cycle takes precedence over the watchdog.
                if (w_sel_done) begin
                    w_next_xmit_l = bus.hnd_xmit[r_sel];
                    w_next_tx_len = bus.hnd_out_len[10*r_sel +: 10];
                    w_next_state  = S_DRAIN;
                end else if (w_timeout) begin
                    w_next_xmit_l = 1'b0;
                    w_next_state  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_sel_done) begin
                    if (r_xmit_l) begin
                        w_next_state = S_TX;
                    end else if (r_sel == LAST_SEL) begin
                        w_next_state = S_RELEASE;
                    end else begin
                        w_next_sel   = r_sel + SEL_W'(1);
                        w_next_state = S_OFFER;
                    end
                end
            end
            S_TX:      w_next_state = S_TXWAIT;
            S_TXWAIT:  if (bus.tx_done) w_next_state = S_RELEASE;
            S_RELEASE: w_next_state = S_RXCLR;
            S_RXCLR:   if (!bus.rx_packet_ready) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end
endmodule
